// File: rtl/sram_pkg.sv
// Shared definitions for the async SRAM pin interface (controller and responder).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // WE-low cycle counter saturates here; MIN_WE must not exceed it.
    localparam logic [2:0] WE_CNT_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_WAIT   = 2'd1,
        ST_RD_DRIVE  = 2'd2,
        ST_WR_ACTIVE = 2'd3
    } sram_state_t;

    // Saturating increment for the WE-low cycle counter.
    function automatic logic [2:0] we_cnt_inc(input logic [2:0] cnt);
        return (cnt == WE_CNT_MAX) ? cnt : cnt + 3'd1;
    endfunction

endpackage

// File: rtl/sram_responder_mem.sv
// Backing array for the SRAM responder: 2**AW x DW, single write port, async read.
// Latency: write lands on the clock edge; read data follows rd_addr combinationally.
// Backpressure: none; every write strobe is accepted.
module sram_responder_mem #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    // Contents survive reset so a board reset does not wipe the emulated device.
    logic [DW-1:0] mem [2**AW];

    // Synchronous write of one word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sram_responder.sv
// Device end of the 16-bit async SRAM pin interface; serves reads/writes from an internal array.
// Latency: read data valid READ_LAT clk edges after first sampled CS=0&OE=0; write commits on WE/CS release.
// Backpressure: none; the controller owns pin timing, violations are only flagged (sticky).
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int MEM_AW   = 10,
    parameter int READ_LAT = 2,
    parameter int MIN_WE   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_pins_out,
    input  logic              data_pins_out_en,
    input  logic              CS,
    input  logic              OE,
    input  logic              WE,
    output logic [DATA_W-1:0] data_pins_in,
    output logic              data_drive,
    output logic              err_contention,
    output logic              err_short_we,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    sram_state_t        state;
    logic [2:0]         lat;
    logic [2:0]         we_cnt;
    logic [ADDR_W-1:0]  cap_addr;
    logic [DATA_W-1:0]  cap_data;

    logic               wr_req;
    logic               rd_req;
    logic               wr_end;
    logic               addr_changed;
    logic               we_long_enough;
    logic               start_rd;
    logic               go_drive;
    logic               mem_wr_en;
    logic [MEM_AW-1:0]  mem_rd_addr;
    logic [DATA_W-1:0]  mem_rd_data;

    // WE low wins over OE low: a cycle with both low is a write.
    assign wr_req         = !CS && !WE;
    assign rd_req         = !CS && !OE && WE;
    assign wr_end         = CS || WE;
    assign addr_changed   = (address != cap_addr);
    assign we_long_enough = (we_cnt >= 3'(MIN_WE));

    // A read (re)starts from IDLE, or from a read state when the controller moves the address.
    assign start_rd = rd_req && ((state == ST_IDLE) || addr_changed);
    // Data goes out once the latency has elapsed on a stable address; READ_LAT=1 drives straight away.
    assign go_drive = (state == ST_RD_WAIT && rd_req && !addr_changed && lat == 3'(READ_LAT - 1))
                   || (start_rd && READ_LAT == 1);

    assign mem_wr_en = (state == ST_WR_ACTIVE) && wr_end && we_long_enough;
    // While waiting the address is held in cap_addr; on a direct start the pins are the address.
    assign mem_rd_addr = (state == ST_RD_WAIT) ? cap_addr[MEM_AW-1:0] : address[MEM_AW-1:0];

    sram_responder_mem #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (cap_addr[MEM_AW-1:0]),
        .wr_data (cap_data),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    // Protocol FSM with capture registers, registered read data, short-WE flag and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            lat          <= '0;
            we_cnt       <= '0;
            cap_addr     <= '0;
            cap_data     <= '0;
            data_pins_in <= '0;
            data_drive   <= 1'b0;
            err_short_we <= 1'b0;
            wr_count     <= '0;
            rd_count     <= '0;
        end else if (wr_req && state != ST_WR_ACTIVE) begin
            state        <= ST_WR_ACTIVE;
            we_cnt       <= 3'd1;
            lat          <= '0;
            cap_addr     <= address;
            cap_data     <= data_pins_out;
            data_drive   <= 1'b0;
            data_pins_in <= '0;
        end else if (state == ST_WR_ACTIVE) begin
            if (!wr_end) begin
                // Last WE-low cycle's pins win, whether or not the controller claims to drive them.
                we_cnt   <= we_cnt_inc(we_cnt);
                cap_addr <= address;
                cap_data <= data_pins_out;
            end else begin
                if (we_long_enough) begin
                    wr_count <= wr_count + 16'd1;
                end else begin
                    err_short_we <= 1'b1;
                end
                state  <= ST_IDLE;
                we_cnt <= '0;
            end
        end else if (go_drive) begin
            state        <= ST_RD_DRIVE;
            cap_addr     <= address;
            lat          <= '0;
            data_pins_in <= mem_rd_data;
            data_drive   <= 1'b1;
            rd_count     <= rd_count + 16'd1;
        end else if (start_rd) begin
            state        <= ST_RD_WAIT;
            cap_addr     <= address;
            lat          <= 3'd1;
            data_drive   <= 1'b0;
            data_pins_in <= '0;
        end else if (!rd_req) begin
            state        <= ST_IDLE;
            lat          <= '0;
            data_drive   <= 1'b0;
            data_pins_in <= '0;
        end else if (state == ST_RD_WAIT) begin
            lat <= lat + 3'd1;
        end
    end

    // Sticky bus-contention flag: both ends driving the data pins in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_contention <= 1'b0;
        end else if (data_drive && data_pins_out_en) begin
            err_contention <= 1'b1;
        end
    end

endmodule
